// File: rtl/conv2_udiv_33ns_18ns_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock, valid/ready on both sides.
// The dividend register doubles as the quotient register as bits shift through it.
module conv2_udiv_33ns_18ns_seq #(
  parameter int unsigned ID         = 1,
  parameter int unsigned din0_WIDTH = 33,
  parameter int unsigned din1_WIDTH = 18
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [din0_WIDTH-1:0] quot,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  div_by_zero
);

  localparam int unsigned RW = din1_WIDTH + 1;
  localparam int unsigned PW = din1_WIDTH + 2;
  localparam int unsigned CW = (din0_WIDTH > 1) ? $clog2(din0_WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e                state_q, state_d;
  logic [din0_WIDTH-1:0] dividend_q, dividend_d;
  logic [din1_WIDTH-1:0] divisor_q, divisor_d;
  logic [RW-1:0]         part_q, part_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  zero_q, zero_d;
  logic [din0_WIDTH-1:0] quot_q, quot_d;
  logic [din1_WIDTH-1:0] rem_q, rem_d;
  logic                  dbz_q, dbz_d;
  logic [PW-1:0]         p;
  logic                  q_bit;

  always_comb begin
    state_d    = state_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    part_d     = part_q;
    cnt_d      = cnt_q;
    zero_d     = zero_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    dbz_d      = dbz_q;
    p          = {part_q, dividend_q[din0_WIDTH-1]};
    q_bit      = (p >= PW'(divisor_q));

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          dividend_d = din0;
          divisor_d  = din1;
          part_d     = '0;
          cnt_d      = CW'(din0_WIDTH - 1);
          zero_d     = (din1 == '0);
          state_d    = StCalc;
        end
      end
      StCalc: begin
        // A zero divisor spends exactly one cycle here so its result lands one edge after accept.
        if (zero_q) begin
          quot_d  = '1;
          rem_d   = dividend_q[din1_WIDTH-1:0];
          dbz_d   = 1'b1;
          state_d = StDone;
        end else begin
          part_d     = q_bit ? RW'(p - PW'(divisor_q)) : p[RW-1:0];
          dividend_d = {dividend_q[din0_WIDTH-2:0], q_bit};
          cnt_d      = cnt_q - CW'(1);
          if (cnt_q == '0) begin
            quot_d  = dividend_d;
            rem_d   = part_d[din1_WIDTH-1:0];
            dbz_d   = 1'b0;
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q    <= StIdle;
      dividend_q <= '0;
      divisor_q  <= '0;
      part_q     <= '0;
      cnt_q      <= '0;
      zero_q     <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      part_q     <= part_d;
      cnt_q      <= cnt_d;
      zero_q     <= zero_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      dbz_q      <= dbz_d;
    end
  end

  assign in_ready    = (state_q == StIdle);
  assign out_valid   = (state_q == StDone);
  assign quot        = quot_q;
  assign rem         = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_conv2_udiv_33ns_18ns_seq.sv
// Bench for conv2_udiv_33ns_18ns_seq: directed cases plus random pairs against an
// arithmetic reference (/ and %), checking results, handshake and latency.
module tb_conv2_udiv_33ns_18ns_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [32:0] din0;
  logic [17:0] din1;
  logic        out_valid;
  logic        out_ready;
  logic [32:0] quot;
  logic [17:0] rem;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  conv2_udiv_33ns_18ns_seq #(
    .ID        (1),
    .din0_WIDTH(33),
    .din1_WIDTH(18)
  ) dut (
    .ap_clk     (clk),
    .ap_rst_n   (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .din0       (din0),
    .din1       (din1),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quot       (quot),
    .rem        (rem),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One transaction from IDLE: present the pair after `gap` idle cycles, wait for the result,
  // hold out_ready low for `stall` cycles, then hand it off. `noise` wiggles in_valid with a
  // different pair while the block is busy; none of it may be accepted.
  task automatic run_op(input logic [32:0] a, input logic [17:0] b, input int gap,
                        input int stall, input bit noise);
    logic [32:0] eq;
    logic [17:0] er;
    logic        ez;
    int          n;
    int          busy_err;
    int          stall_err;
    logic [63:0] prod;
    if (b == 18'd0) begin
      eq = '1;
      er = a[17:0];
      ez = 1'b1;
    end else begin
      eq = 33'(a / 33'(b));
      er = 18'(a % 33'(b));
      ez = 1'b0;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (gap) @(negedge clk);
    check("in_ready_idle", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    din0     = a;
    din1     = b;
    @(negedge clk);
    in_valid  = noise ? 1'($urandom) : 1'b0;
    din0      = 33'd20;
    din1      = 18'd3;
    n         = 0;
    busy_err  = 0;
    while (!out_valid && n < 100) begin
      if (in_ready) busy_err++;
      @(negedge clk);
      in_valid = noise ? 1'($urandom) : 1'b0;
      n++;
    end
    check("latency", 64'(n), (b == 18'd0) ? 64'd1 : 64'd33);
    check("in_ready_busy", 64'(busy_err), 64'd0);
    stall_err = 0;
    for (int s = 0; s < stall; s++) begin
      if (quot !== eq || rem !== er || div_by_zero !== ez || !out_valid || in_ready)
        stall_err++;
      @(negedge clk);
      in_valid = noise ? 1'($urandom) : 1'b0;
    end
    check("stall_stable", 64'(stall_err), 64'd0);
    in_valid = 1'b0;
    check("out_valid", 64'(out_valid), 64'd1);
    check("in_ready_done", 64'(in_ready), 64'd0);
    check("quot", 64'(quot), 64'(eq));
    check("rem", 64'(rem), 64'(er));
    check("div_by_zero", 64'(div_by_zero), 64'(ez));
    if (b != 18'd0) begin
      prod = 64'(quot) * 64'(b) + 64'(rem);
      check("identity", prod, 64'(a));
      check("rem_lt_divisor", 64'(rem < b), 64'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_after_hs", 64'(out_valid), 64'd0);
    check("in_ready_after_hs", 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [32:0] a;
    logic [17:0] b;
    int          sel;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    din0      = '0;
    din1      = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_quot", 64'(quot), 64'd0);
    check("rst_rem", 64'(rem), 64'd0);
    check("rst_dbz", 64'(div_by_zero), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(33'd100000, 18'd300, 0, 0, 1'b0);
    run_op(33'h1_FFFF_FFFF, 18'd1, 0, 0, 1'b0);
    run_op(33'h1_FFFF_FFFF, 18'h3FFFF, 1, 0, 1'b0);
    run_op(33'd5, 18'd7, 0, 0, 1'b0);
    run_op(33'd12345, 18'd0, 0, 0, 1'b0);
    run_op(33'd1000, 18'd7, 0, 10, 1'b1);

    // Async reset in the middle of 1000/7.
    in_valid = 1'b1;
    din0     = 33'd1000;
    din1     = 18'd7;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (16) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midcalc_rst_in_ready", 64'(in_ready), 64'd1);
    check("midcalc_rst_out_valid", 64'(out_valid), 64'd0);
    check("midcalc_rst_quot", 64'(quot), 64'd0);
    check("midcalc_rst_rem", 64'(rem), 64'd0);
    check("midcalc_rst_dbz", 64'(div_by_zero), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(33'd81, 18'd9, 0, 0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      a   = {1'($urandom), 32'($urandom)};
      sel = int'($urandom_range(0, 7));
      case (sel)
        0:       b = ($urandom_range(0, 3) == 0) ? 18'd0 : 18'd1;
        1:       b = 18'h3FFFF;
        2:       b = 18'($urandom_range(1, 16));
        3:       begin b = 18'($urandom); a = 33'($urandom_range(0, 1000)); end
        default: b = 18'($urandom);
      endcase
      run_op(a, b, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
